sr_latch_driver: RTL and testbench

Synchronous driver for an external cross-coupled SR latch. It accepts one set/clear request at a time over a valid/ready handshake and generates a single clean, fixed-width S or R pulse, never both at once. It then confirms, through a synchronised read-back of Q/Qn, that the latch reached the requested state. It sits between clocked control logic and the asynchronous `sr_latch` storage element and reports completion or a timeout error.

---
 rtl/sr_latch_driver.sv | 145 ++++++++++++++
 tb/tb_sr_latch_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Clocked driver for an external cross-coupled SR latch: one set/clear request at a
// time, a fixed-width S or R pulse, then a synchronised read-back check with timeout.
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; req_val is sampled on that edge only. The requester keeps
  // req_valid asserted until the transfer, and both inputs are ignored otherwise.
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_val,
  output logic       S,
  output logic       R,
  input  logic       Q,
  input  logic       Qn,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int MAX_PT = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
  localparam int MAX_V  = (MAX_PT > GAP_W) ? MAX_PT : GAP_W;
  localparam int CW     = $clog2(MAX_V) + 1;

  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_W - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          val_r, val_nxt;
  logic          s_nxt, r_nxt, done_nxt, err_nxt;
  logic          q_s1, q_s, qn_s1, qn_s;
  logic          match;

  // Q/Qn are asynchronous to clk; only the second-stage values are ever used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1  <= 1'b0;
      q_s   <= 1'b0;
      qn_s1 <= 1'b0;
      qn_s  <= 1'b0;
    end else begin
      q_s1  <= Q;
      q_s   <= q_s1;
      qn_s1 <= Qn;
      qn_s  <= qn_s1;
    end
  end

  // Q==Qn can never satisfy this, so an invalid read-back is simply waited out.
  assign match = (q_s == val_r) && (qn_s == ~val_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= CNT_ZERO;
      val_r <= 1'b0;
      S     <= 1'b0;
      R     <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      val_r <= val_nxt;
      S     <= s_nxt;
      R     <= r_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    val_nxt   = val_r;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          val_nxt   = req_val;
          cnt_nxt   = PULSE_LD;
          state_nxt = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt == CNT_ZERO) begin
          cnt_nxt   = SETTLE_LD;
          state_nxt = ST_SETTLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (match) begin
          done_nxt  = 1'b1;
          cnt_nxt   = GAP_LD;
          state_nxt = ST_GAP;
        end else if (cnt == CNT_ZERO) begin
          err_nxt   = 1'b1;
          cnt_nxt   = GAP_LD;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt == CNT_ZERO) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
    // Drives are registered from the next state so S and R are exclusive by
    // construction and glitch-free at the pins.
    s_nxt = (state_nxt == ST_PULSE) &&  val_nxt;
    r_nxt = (state_nxt == ST_PULSE) && !val_nxt;
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign dbg_state = state;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural SR latch, directed request table, hand
// sequences for reset and invalid read-back, and a randomized run against a model.
module tb_sr_latch_driver;

  localparam int PW   = 4;
  localparam int GW   = 2;
  localparam int TO   = 16;
  localparam int NLOG = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_val;
  logic       req_ready, S, R, done, err, busy;
  logic       Q, Qn;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Latch model plus forcing: 0 free, 1 stuck Q=0, 2 Q=Qn=1, 3 stuck Q=1
  logic q_l = 1'b0;
  int   fmode = 0;
  assign Q  = (fmode == 1) ? 1'b0 : (fmode == 2) ? 1'b1 : (fmode == 3) ? 1'b1 : q_l;
  assign Qn = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'b1 : (fmode == 3) ? 1'b0 : ~q_l;

  // Logs: inputs sampled at edge k, outputs observed in the cycle after edge k
  logic       i_vld[NLOG];
  logic       i_val[NLOG];
  logic       i_q[NLOG];
  logic       i_qn[NLOG];
  logic       acc_log[NLOG];
  logic [4:0] o_log[NLOG];
  logic [4:0] exp_o[NLOG];

  typedef struct {
    logic val;
    int   fm;
    int   rel_off;
    int   done_off;
    int   err_off;
    int   rdy_off;
    int   s_cnt;
    int   r_cnt;
    int   q_end;
  } vec_t;

  vec_t tbl[8];

  sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_val   (req_val),
    .S         (S),
    .R         (R),
    .Q         (Q),
    .Qn        (Qn),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < NLOG) begin
      i_vld[cyc]   = req_valid;
      i_val[cyc]   = req_val;
      i_q[cyc]     = Q;
      i_qn[cyc]    = Qn;
      acc_log[cyc] = req_valid & req_ready;
    end
  end

  always @(negedge clk) begin
    if (cyc < NLOG) o_log[cyc] <= {S, R, done, err, req_ready};
    total = total + 1;
    if (S && R) begin
      bad = bad + 1;
      $display("FAIL s_and_r cycle=%0d S=%b R=%b required=not both", cyc, S, R);
    end
    if (S && !R) q_l <= 1'b1;
    else if (R && !S) q_l <= 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  d_off, e_off, r_off, s_cnt, r_cnt, p_first, d_cnt, e_cnt;
    bit  acc;
    d_off = 0; e_off = 0; r_off = 0; s_cnt = 0; r_cnt = 0;
    p_first = 0; d_cnt = 0; e_cnt = 0;
    @(negedge clk); #1;
    fmode = v.fm; req_valid = 1'b1; req_val = v.val;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = acc_log[cyc];
    end
    if (!acc) begin
      chk($sformatf("v%0d_accept_timeout", id), 0, 1);
      req_valid = 1'b0; fmode = 0;
      return;
    end
    for (int off = 1; off <= 30; off++) begin
      if (off > 1) @(negedge clk);
      if (S) begin s_cnt++; if (p_first == 0) p_first = off; end
      if (R) begin r_cnt++; if (p_first == 0) p_first = off; end
      if (done) begin d_cnt++; if (d_off == 0) d_off = off; end
      if (err) begin e_cnt++; if (e_off == 0) e_off = off; end
      if (req_ready && r_off == 0) r_off = off;
      if (off == 1) begin #1 req_valid = 1'b0; end
      if (off == v.rel_off) begin #1 fmode = 0; end
    end
    chk($sformatf("v%0d_pulse_first", id), p_first, 1);
    chk($sformatf("v%0d_s_cycles", id), s_cnt, v.s_cnt);
    chk($sformatf("v%0d_r_cycles", id), r_cnt, v.r_cnt);
    chk($sformatf("v%0d_done_cycle", id), d_off, v.done_off);
    chk($sformatf("v%0d_err_cycle", id), e_off, v.err_off);
    chk($sformatf("v%0d_done_count", id), d_cnt, (v.done_off != 0) ? 1 : 0);
    chk($sformatf("v%0d_err_count", id), e_cnt, (v.err_off != 0) ? 1 : 0);
    chk($sformatf("v%0d_ready_cycle", id), r_off, v.rdy_off);
    if (v.q_end >= 0) chk($sformatf("v%0d_q_end", id), int'(Q), v.q_end);
    #1 fmode = 0;
  endtask

  // Reference: accept on the first valid edge when free; pulse PW cycles; the
  // synchronised read-back in output cycle k is the Q sampled at edge k-1.
  task automatic compare_segment(input int s, input int e_end, input string tag);
    int   free, e, g;
    logic v;
    bit   hit;
    for (int i = s; i <= e_end; i++) exp_o[i] = 5'b00001;
    free = s;
    while (free <= e_end) begin
      e = -1;
      for (int k = free; k <= e_end; k++) begin
        if (i_vld[k]) begin e = k; break; end
      end
      if (e < 0) break;
      v = i_val[e];
      for (int k = e; k < e + PW; k++) if (k <= e_end) exp_o[k][4:3] = v ? 2'b10 : 2'b01;
      g = e + PW + TO;
      hit = 1'b0;
      for (int k = e + PW; k < e + PW + TO; k++) begin
        if (!hit && i_q[k-1] == v && i_qn[k-1] == !v) begin g = k + 1; hit = 1'b1; end
      end
      if (g <= e_end) exp_o[g][2:1] = hit ? 2'b10 : 2'b01;
      for (int k = e; k < g + GW; k++) if (k <= e_end) exp_o[k][0] = 1'b0;
      free = g + GW + 1;
    end
    for (int i = s; i <= e_end; i++) begin
      total = total + 1;
      if (o_log[i] !== exp_o[i]) begin
        bad = bad + 1;
        $display("FAIL %s cycle=%0d act=%b exp=%b (S R done err ready)", tag, i, o_log[i], exp_o[i]);
      end
    end
  endtask

  initial begin
    int s, e_end, prev, nacc, d_cnt, e_cnt, rdy_cnt;
    tbl[0] = '{1'b1, 0, 0,  6,  0,  8, 4, 0,  1};
    tbl[1] = '{1'b0, 0, 0,  6,  0,  8, 0, 4,  0};
    tbl[2] = '{1'b1, 0, 0,  6,  0,  8, 4, 0,  1};
    tbl[3] = '{1'b1, 0, 0,  6,  0,  8, 4, 0,  1};
    tbl[4] = '{1'b1, 1, 0,  0, 21, 23, 4, 0, -1};
    tbl[5] = '{1'b0, 0, 0,  6,  0,  8, 0, 4,  0};
    tbl[6] = '{1'b1, 2, 9, 12,  0, 14, 4, 0,  1};
    tbl[7] = '{1'b0, 3, 0,  0, 21, 23, 0, 4, -1};

    rst_n = 1'b0; req_valid = 1'b0; req_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_S", int'(S), 0);
    chk("reset_R", int'(R), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_ready", int'(req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Back-to-back: valid held, val toggling every cycle
    @(negedge clk);
    s = cyc + 1;
    #1 req_valid = 1'b1; req_val = 1'b0;
    repeat (70) begin
      @(negedge clk);
      #1 req_val = ~req_val;
    end
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
    #1 e_end = cyc;
    compare_segment(s, e_end, "b2b");
    prev = -1; nacc = 0;
    for (int k = s; k <= e_end; k++) begin
      if (acc_log[k]) begin
        if (prev >= 0) chk("b2b_spacing", k - prev, PW + GW + 2);
        prev = k; nacc++;
      end
    end
    chk("b2b_enough_accepts", int'(nacc >= 8), 1);

    // Randomized traffic with occasional read-back faults
    @(negedge clk);
    s = cyc + 1;
    repeat (1500) begin
      #1;
      req_valid = ($urandom_range(0, 3) != 0);
      req_val   = 1'($urandom_range(0, 1));
      if (fmode != 0) begin
        if ($urandom_range(0, 7) == 0) fmode = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        fmode = int'($urandom_range(1, 3));
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0; fmode = 0;
    repeat (40) @(negedge clk);
    #1 e_end = cyc;
    compare_segment(s, e_end, "rand");

    // Reset in the middle of a set pulse
    @(negedge clk); #1;
    req_valid = 1'b1; req_val = 1'b1;
    begin : wait_acc
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge clk);
        acc = acc_log[cyc];
      end
      chk("rst_accept", int'(acc), 1);
    end
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_S", int'(S), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_S", int'(S), 0);
    chk("rst_async_R", int'(R), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    d_cnt = 0; e_cnt = 0; rdy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) d_cnt++;
      if (err) e_cnt++;
      if (req_ready) rdy_cnt++;
    end
    chk("rst_after_done", d_cnt, 0);
    chk("rst_after_err", e_cnt, 0);
    chk("rst_after_ready", rdy_cnt, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad = bad + 1;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
